// File: rtl/tcdm_port_arbiter.sv
// tcdm_port_arbiter: round-robin sharing of one TCDM port with ID remapping through an outstanding table
module tcdm_port_arbiter #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdWidth = 4,
    parameter int unsigned NumOutstanding = 8,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned StrbWidth = DataWidth / 8,
    localparam int unsigned CntWidth = $clog2(NumOutstanding + 1),
    localparam int unsigned ReqWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0][31:0]             req_qaddr_i,
    input  logic [NumReq-1:0]                   req_qwrite_i,
    input  logic [NumReq-1:0][3:0]              req_qamo_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_qdata_i,
    input  logic [NumReq-1:0][StrbWidth-1:0]    req_qstrb_i,
    input  logic [NumReq-1:0][IdWidth-1:0]      req_qid_i,
    input  logic [NumReq-1:0]                   req_qvalid_i,
    output logic [NumReq-1:0]                   req_qready_o,
    output logic [NumReq-1:0][DataWidth-1:0]    req_pdata_o,
    output logic [NumReq-1:0]                   req_perror_o,
    output logic [NumReq-1:0][IdWidth-1:0]      req_pid_o,
    output logic [NumReq-1:0]                   req_pvalid_o,
    input  logic [NumReq-1:0]                   req_pready_i,
    output logic [31:0]                         data_qaddr_o,
    output logic                                data_qwrite_o,
    output logic [3:0]                          data_qamo_o,
    output logic [DataWidth-1:0]                data_qdata_o,
    output logic [StrbWidth-1:0]                data_qstrb_o,
    output logic [IdWidth-1:0]                  data_qid_o,
    output logic                                data_qvalid_o,
    input  logic                                data_qready_i,
    input  logic [DataWidth-1:0]                data_pdata_i,
    input  logic                                data_perror_i,
    input  logic [IdWidth-1:0]                  data_pid_i,
    input  logic                                data_pvalid_i,
    output logic                                data_pready_o,
    output logic [CntWidth-1:0]                 outstanding_o,
    output logic                                err_unexpected_o
);
    logic [NumOutstanding-1:0] valid;
    logic [NumOutstanding-1:0][ReqWidth-1:0] owner;
    logic [NumOutstanding-1:0][IdWidth-1:0] ids;
    logic [ReqWidth-1:0] rr_ptr, lock_req, arb_win, win, hit_owner;
    logic [IdWidth-1:0] lock_slot, free_slot, slot, hit_id;
    logic lock, locked, arb_any, full, alloc, hit_valid, hit, rel, err;
    logic [CntWidth-1:0] cnt, live;

    // Lowest valid requester overall, then overridden by the lowest one at or above the pointer.
    always_comb begin
        arb_any = 1'b0;
        arb_win = '0;
        for (int i = int'(NumReq) - 1; i >= 0; i--)
            if (req_qvalid_i[i]) begin
                arb_any = 1'b1;
                arb_win = ReqWidth'(i);
            end
        for (int i = int'(NumReq) - 1; i >= 0; i--)
            if (req_qvalid_i[i] && i >= int'(rr_ptr)) arb_win = ReqWidth'(i);
    end

    always_comb begin
        free_slot = '0;
        for (int i = int'(NumOutstanding) - 1; i >= 0; i--)
            if (!valid[i]) free_slot = IdWidth'(i);
    end

    // A stalled request keeps its requester and slot; dropping valid releases the lock.
    assign full = &valid;
    assign locked = lock && req_qvalid_i[lock_req];
    assign win = locked ? lock_req : arb_win;
    assign slot = locked ? lock_slot : free_slot;
    assign data_qvalid_o = (locked || arb_any) && !full;
    assign alloc = data_qvalid_o && data_qready_i;
    assign data_qaddr_o = req_qaddr_i[win];
    assign data_qwrite_o = req_qwrite_i[win];
    assign data_qamo_o = req_qamo_i[win];
    assign data_qdata_o = req_qdata_i[win];
    assign data_qstrb_o = req_qstrb_i[win];
    assign data_qid_o = slot;

    always_comb begin
        req_qready_o = '0;
        req_qready_o[win] = alloc;
    end

    // Out-of-range slot IDs never match an entry and fall through as unexpected.
    always_comb begin
        hit_valid = 1'b0;
        hit_owner = '0;
        hit_id = '0;
        for (int i = 0; i < int'(NumOutstanding); i++)
            if (data_pid_i == IdWidth'(i)) begin
                hit_valid = valid[i];
                hit_owner = owner[i];
                hit_id = ids[i];
            end
    end

    assign hit = data_pvalid_i && hit_valid;
    assign rel = hit && req_pready_i[hit_owner];
    assign data_pready_o = hit ? req_pready_i[hit_owner] : data_pvalid_i;
    assign req_pdata_o = {NumReq{data_pdata_i}};
    assign req_perror_o = {NumReq{data_perror_i}};

    always_comb begin
        req_pvalid_o = '0;
        req_pid_o = '0;
        req_pvalid_o[hit_owner] = hit;
        req_pid_o[hit_owner] = hit ? hit_id : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
            rr_ptr <= '0;
            lock <= 1'b0;
            lock_req <= '0;
            lock_slot <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NumOutstanding); i++) begin
                if (rel && data_pid_i == IdWidth'(i)) valid[i] <= 1'b0;
                if (alloc && slot == IdWidth'(i)) begin
                    valid[i] <= 1'b1;
                    owner[i] <= win;
                    ids[i] <= req_qid_i[win];
                end
            end
            if (alloc) rr_ptr <= (int'(win) == int'(NumReq) - 1) ? '0 : win + 1'b1;
            lock <= data_qvalid_o && !data_qready_i;
            lock_req <= win;
            lock_slot <= slot;
            cnt <= cnt + CntWidth'(alloc) - CntWidth'(rel);
            err <= err || (data_pvalid_i && !hit_valid);
        end
    end

    assign outstanding_o = cnt;
    assign err_unexpected_o = err;

    always_comb begin
        live = '0;
        for (int i = 0; i < int'(NumOutstanding); i++) live = live + CntWidth'(valid[i]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(alloc && full));
            assert (cnt == live);
        end
    end
endmodule

// File: tb/tb_tcdm_port_arbiter.sv
// tb_tcdm_port_arbiter: directed vector checks of arbitration, slot remapping, lock, full and reset
module tb_tcdm_port_arbiter;
    localparam int NR = 2;
    localparam int IW = 4;
    localparam int NO = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0][31:0] req_qaddr_i;
    logic [NR-1:0] req_qwrite_i;
    logic [NR-1:0][3:0] req_qamo_i;
    logic [NR-1:0][DW-1:0] req_qdata_i;
    logic [NR-1:0][DW/8-1:0] req_qstrb_i;
    logic [NR-1:0][IW-1:0] req_qid_i;
    logic [NR-1:0] req_qvalid_i;
    logic [NR-1:0] req_qready_o;
    logic [NR-1:0][DW-1:0] req_pdata_o;
    logic [NR-1:0] req_perror_o;
    logic [NR-1:0][IW-1:0] req_pid_o;
    logic [NR-1:0] req_pvalid_o;
    logic [NR-1:0] req_pready_i;
    logic [31:0] data_qaddr_o;
    logic data_qwrite_o;
    logic [3:0] data_qamo_o;
    logic [DW-1:0] data_qdata_o;
    logic [DW/8-1:0] data_qstrb_o;
    logic [IW-1:0] data_qid_o;
    logic data_qvalid_o;
    logic data_qready_i;
    logic [DW-1:0] data_pdata_i;
    logic data_perror_i;
    logic [IW-1:0] data_pid_i;
    logic data_pvalid_i;
    logic data_pready_o;
    logic [3:0] outstanding_o;
    logic err_unexpected_o;

    int nchk = 0;
    int nfail = 0;
    int step = 0;

    always #5 clk = ~clk;

    tcdm_port_arbiter #(.NumReq(NR), .IdWidth(IW), .NumOutstanding(NO), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_qaddr_i(req_qaddr_i), .req_qwrite_i(req_qwrite_i), .req_qamo_i(req_qamo_i),
        .req_qdata_i(req_qdata_i), .req_qstrb_i(req_qstrb_i), .req_qid_i(req_qid_i),
        .req_qvalid_i(req_qvalid_i), .req_qready_o(req_qready_o),
        .req_pdata_o(req_pdata_o), .req_perror_o(req_perror_o), .req_pid_o(req_pid_o),
        .req_pvalid_o(req_pvalid_o), .req_pready_i(req_pready_i),
        .data_qaddr_o(data_qaddr_o), .data_qwrite_o(data_qwrite_o), .data_qamo_o(data_qamo_o),
        .data_qdata_o(data_qdata_o), .data_qstrb_o(data_qstrb_o), .data_qid_o(data_qid_o),
        .data_qvalid_o(data_qvalid_o), .data_qready_i(data_qready_i),
        .data_pdata_i(data_pdata_i), .data_perror_i(data_perror_i), .data_pid_i(data_pid_i),
        .data_pvalid_i(data_pvalid_i), .data_pready_o(data_pready_o),
        .outstanding_o(outstanding_o), .err_unexpected_o(err_unexpected_o)
    );

    typedef struct {
        logic [1:0] qv;
        logic [3:0] id0;
        logic [3:0] id1;
        logic qr;
        logic pv;
        logic [3:0] pid;
        logic [1:0] prdy;
        logic [1:0] e_qrdy;
        logic e_dqv;
        logic [3:0] e_qid;
        logic [31:0] e_addr;
        logic [1:0] e_pv;
        logic [3:0] e_pid;
        logic e_prdy;
        logic [3:0] e_cnt;
        logic e_err;
    } vec_t;

    function automatic vec_t mk(int qv, int id0, int id1, int qr, int pv, int pid, int prdy,
                                int e_qrdy, int e_dqv, int e_qid, int e_addr, int e_pv,
                                int e_pid, int e_prdy, int e_cnt, int e_err);
        vec_t r;
        r.qv = 2'(qv);
        r.id0 = 4'(id0);
        r.id1 = 4'(id1);
        r.qr = 1'(qr);
        r.pv = 1'(pv);
        r.pid = 4'(pid);
        r.prdy = 2'(prdy);
        r.e_qrdy = 2'(e_qrdy);
        r.e_dqv = 1'(e_dqv);
        r.e_qid = 4'(e_qid);
        r.e_addr = 32'(e_addr);
        r.e_pv = 2'(e_pv);
        r.e_pid = 4'(e_pid);
        r.e_prdy = 1'(e_prdy);
        r.e_cnt = 4'(e_cnt);
        r.e_err = 1'(e_err);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL step %0d %s: got %0h expected %0h", step, name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] pd;
        pd = 32'hCAFE0000 | 32'(step);
        req_qvalid_i = v.qv;
        req_qid_i[0] = v.id0;
        req_qid_i[1] = v.id1;
        data_qready_i = v.qr;
        data_pvalid_i = v.pv;
        data_pid_i = v.pid;
        req_pready_i = v.prdy;
        data_pdata_i = pd;
        #2;
        check("qready", 32'(req_qready_o), 32'(v.e_qrdy));
        check("qvalid", 32'(data_qvalid_o), 32'(v.e_dqv));
        if (v.e_dqv) begin
            check("qid", 32'(data_qid_o), 32'(v.e_qid));
            check("qaddr", data_qaddr_o, v.e_addr);
        end
        check("pvalid", 32'(req_pvalid_o), 32'(v.e_pv));
        if (v.e_pv != 2'b00) begin
            check("pid", 32'(req_pid_o[v.e_pv[1]]), 32'(v.e_pid));
            check("pdata", req_pdata_o[v.e_pv[1]], pd);
        end
        check("pready", 32'(data_pready_o), 32'(v.e_prdy));
        check("outstanding", 32'(outstanding_o), 32'(v.e_cnt));
        check("err", 32'(err_unexpected_o), 32'(v.e_err));
        @(negedge clk);
        step++;
    endtask

    task automatic do_reset(input logic [1:0] qv, input logic qr);
        rst = 1'b1;
        req_qvalid_i = qv;
        data_qready_i = qr;
        data_pvalid_i = 1'b0;
        req_pready_i = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        req_qaddr_i[0] = 32'h100;
        req_qaddr_i[1] = 32'h200;
        req_qdata_i[0] = 32'hD0;
        req_qdata_i[1] = 32'hD1;
        req_qwrite_i = '0;
        req_qamo_i = '0;
        req_qstrb_i = '1;
        req_qid_i = '0;
        req_qvalid_i = '0;
        req_pready_i = '0;
        data_qready_i = 1'b0;
        data_pdata_i = '0;
        data_perror_i = 1'b0;
        data_pid_i = '0;
        data_pvalid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // alternating grants, out-of-order and backpressured responses, concurrent alloc/free, unexpected
        tbl[0]  = mk(3, 5, 9, 1, 0, 0, 0, 1, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        tbl[1]  = mk(3, 5, 9, 1, 0, 0, 0, 2, 1, 1, 32'h200, 0, 0, 0, 1, 0);
        tbl[2]  = mk(3, 5, 9, 1, 0, 0, 0, 1, 1, 2, 32'h100, 0, 0, 0, 2, 0);
        tbl[3]  = mk(3, 5, 9, 1, 0, 0, 0, 2, 1, 3, 32'h200, 0, 0, 0, 3, 0);
        tbl[4]  = mk(0, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        tbl[5]  = mk(0, 5, 9, 0, 1, 1, 3, 0, 0, 0, 0, 2, 9, 1, 4, 0);
        tbl[6]  = mk(0, 5, 9, 0, 1, 0, 3, 0, 0, 0, 0, 1, 5, 1, 3, 0);
        tbl[7]  = mk(0, 5, 9, 0, 1, 3, 1, 0, 0, 0, 0, 2, 9, 0, 2, 0);
        tbl[8]  = mk(0, 5, 9, 0, 1, 3, 1, 0, 0, 0, 0, 2, 9, 0, 2, 0);
        tbl[9]  = mk(0, 5, 9, 0, 1, 3, 3, 0, 0, 0, 0, 2, 9, 1, 2, 0);
        tbl[10] = mk(1, 5, 9, 1, 1, 2, 3, 1, 1, 0, 32'h100, 1, 5, 1, 1, 0);
        tbl[11] = mk(0, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk(0, 5, 9, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[13] = mk(0, 5, 9, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        tbl[14] = mk(0, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) run_vec(tbl[i]);
        // stall keeps requester and slot even after a lower slot frees up
        do_reset(2'b00, 1'b0);
        run_vec(mk(1, 5, 9, 1, 0, 0, 0, 1, 1, 0, 32'h100, 0, 0, 0, 0, 0));
        run_vec(mk(3, 5, 9, 0, 0, 0, 0, 0, 1, 1, 32'h200, 0, 0, 0, 1, 0));
        run_vec(mk(3, 5, 9, 0, 1, 0, 3, 0, 1, 1, 32'h200, 1, 5, 1, 1, 0));
        run_vec(mk(3, 5, 9, 0, 0, 0, 0, 0, 1, 1, 32'h200, 0, 0, 0, 0, 0));
        run_vec(mk(3, 5, 9, 1, 0, 0, 0, 2, 1, 1, 32'h200, 0, 0, 0, 0, 0));
        run_vec(mk(3, 5, 9, 1, 0, 0, 0, 1, 1, 0, 32'h100, 0, 0, 0, 1, 0));
        run_vec(mk(0, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        // fill the table, block, free slot 3, reuse it only on the following cycle
        do_reset(2'b00, 1'b0);
        for (int i = 0; i < NO; i++) run_vec(mk(1, 5, 9, 1, 0, 0, 0, 1, 1, i, 32'h100, 0, 0, 0, i, 0));
        run_vec(mk(1, 5, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        run_vec(mk(1, 5, 9, 1, 1, 3, 3, 0, 0, 0, 0, 1, 5, 1, 8, 0));
        run_vec(mk(1, 5, 9, 1, 0, 0, 0, 1, 1, 3, 32'h100, 0, 0, 0, 7, 0));
        run_vec(mk(1, 5, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        run_vec(mk(0, 5, 9, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0));
        // reset with traffic pending: stale slot responses become unexpected
        do_reset(2'b01, 1'b1);
        run_vec(mk(0, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk(0, 5, 9, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        run_vec(mk(0, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // locked requester drops valid: lock released, other requester arbitrated
        run_vec(mk(1, 5, 9, 0, 0, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0, 1));
        run_vec(mk(2, 5, 9, 0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 0, 0, 0, 1));
        run_vec(mk(0, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/tcdm_port_arbiter.md
Name: tcdm_port_arbiter

Overview:
Shares one TCDM data port between NumReq requesters, e.g. a core's LSU and a second requester such as a DMA or accelerator, in front of the tile's TCDM/lrwait path. It arbitrates requests round-robin and replaces each requester's ID with a free slot index from an outstanding-transaction table. Responses are routed back by table lookup with the original ID restored, so out-of-order bank responses are supported.

Parameters:
NumReq, 2, number of requesters (2..8)
IdWidth, 4, width of requester IDs and of the TCDM meta ID
NumOutstanding, 8, table entries; must satisfy 1 <= NumOutstanding <= 2**IdWidth
DataWidth, 32, data width; strobe width is DataWidth/8

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock, reset is synchronous and active-high
req_qaddr_i  in  NumReq x 32  request address
req_qwrite_i  in  NumReq x 1  write enable
req_qamo_i  in  NumReq x 4  AMO opcode
req_qdata_i  in  NumReq x DataWidth  write data
req_qstrb_i  in  NumReq x DataWidth/8  byte strobe
req_qid_i  in  NumReq x IdWidth  requester transaction ID
req_qvalid_i  in  NumReq  request valid
req_qready_o  out  NumReq  request ready
req_pdata_o  out  NumReq x DataWidth  response data (broadcast)
req_perror_o  out  NumReq  response error (broadcast)
req_pid_o  out  NumReq x IdWidth  restored original ID
req_pvalid_o  out  NumReq  response valid (one-hot)
req_pready_i  in  NumReq  response ready
data_qaddr_o, data_qwrite_o, data_qamo_o, data_qdata_o, data_qstrb_o  out  as above  muxed request fields
data_qid_o  out  IdWidth  allocated slot index
data_qvalid_o  out  1  port request valid
data_qready_i  in  1  port request ready
data_pdata_i  in  DataWidth  port response data
data_perror_i  in  1  port response error
data_pid_i  in  IdWidth  slot index of response
data_pvalid_i  in  1  port response valid
data_pready_o  out  1  port response ready
outstanding_o  out  $clog2(NumOutstanding+1)  live table entries
err_unexpected_o  out  1  sticky: response hit a free or out-of-range slot

Behaviour:
- Reset: table all invalid, RR pointer 0, lock cleared, outstanding_o=0, err_unexpected_o=0. All valid/ready outputs are combinationally 0 when no stimulus is applied.
- Request path is combinational, 0-cycle latency. Winner is the first valid requester at or after the RR pointer.
- Full: if no free slot, data_qvalid_o=0 and all req_qready_o=0.
- Alloc slot = lowest-index invalid entry, taken from the registered table state.
- req_qready_o[w] = data_qready_i for the winner only; all other readys are 0.
- Lock: if data_qvalid_o=1 and data_qready_i=0, the winner and slot are latched. Next cycle the same requester is presented with the same data_qid_o, and the higher-priority arbitration is ignored until the handshake completes.
- Lock drop: the lock also clears if the locked requester drops its valid, which is a protocol violation, tolerated without error.
- Handshake (data_qvalid_o & data_qready_i): entry[slot] <= {valid=1, owner=w, id=req_qid_i[w]}. RR pointer <= w+1, wrapping modulo NumReq.
- Response path is combinational, 0-cycle latency. When data_pvalid_i=1 and entry[data_pid_i] is valid: req_pvalid_o[owner]=1, req_pid_o[owner]=stored id, data_pready_o=req_pready_i[owner]. Data and error pass through unchanged.
- Free: on response handshake the entry is cleared at the clock edge. A slot freed in cycle t is allocatable from cycle t+1, never in the same cycle.
- Unexpected response (entry invalid, or data_pid_i >= NumOutstanding): data_pready_o=1 (dropped), no req_pvalid_o, err_unexpected_o <= 1 until reset.
- Counter: outstanding_o increments on alloc and decrements on free. Simultaneous alloc and free leaves it unchanged. It never exceeds NumOutstanding.
- Reset mid-operation: table is flushed. Responses arriving later for pre-reset slots are treated as unexpected.
- Assertions: no alloc when full; outstanding_o equals the popcount of valid entries.

Test Plan:
- Alternating grant: both requesters valid every cycle, data_qready_i=1 -> grants alternate 0,1,0,1; data_qid_o=0,1,2,3; outstanding_o reaches 4.
- Stall and lock: req0 and req1 valid, data_qready_i=0 for 3 cycles -> req0 held with stable addr and qid=0, req1_qready=0; on ready, req0 completes, then req1 is granted with qid=1.
- Out-of-order response: req0 id=5 gets slot 0, req1 id=9 gets slot 1; responses arrive with pid=1 then pid=0 -> req1 sees pid=9 first, then req0 sees pid=5.
- Full and backpressure: NumOutstanding=8, issue 8 requests with no responses -> 9th blocked, qready=0, outstanding_o=8. One response on slot 3 -> next request allocated slot 3 one cycle later.
- Response backpressure: response for req1 with req_pready_i[1]=0 for 2 cycles -> data_pready_o=0, entry stays valid; released on ready.
- Unexpected response and reset: data_pvalid_i with pid=6 unallocated -> data_pready_o=1, err_unexpected_o=1 sticky; rst_i pulse mid-traffic -> table cleared, outstanding_o=0, err cleared.
